// File: rtl/mdu_scheduler_pkg.sv
// MDU type codes, default latencies and sequencer state shared by the scheduler slice.
// Pure declarations, no timing. MDU_MADD_EN adds the madd/maddu codes to the md class.
package mdu_scheduler_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10
  } mdu_type_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  localparam int MDU_MULT_LAT_DEF = 5;
  localparam int MDU_DIV_LAT_DEF  = 10;

  // Operations that occupy the unit for a full latency window.
  function automatic logic is_md(logic [3:0] t);
    case (t)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div(logic [3:0] t);
    return (t == MDU_DIV) || (t == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_scheduler_if.sv
// E/D-stage handshake between the pipeline (master) and the MDU scheduler (slave).
// Carries E-stage operation, D-stage MDU hint, and the unit's busy/stall/readback.
interface mdu_scheduler_if;
  logic [3:0]  type_E;
  logic        start_E;
  logic        kill;
  logic [31:0] a;
  logic [31:0] b;
  logic        mdu_D;
  logic        busy;
  logic        stall;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output type_E, start_E, kill, a, b, mdu_D,
    input  busy, stall, rdata, hi, lo
  );

  modport slave (
    input  type_E, start_E, kill, a, b, mdu_D,
    output busy, stall, rdata, hi, lo
  );
endinterface

// File: rtl/mdu_core.sv
// Combinational product / quotient / remainder for one MDU op; no state.
// Zero latency; divide by zero is flagged and uses a dummy divisor of 1.
module mdu_core
  import mdu_scheduler_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic [31:0]        dvs;

  assign sprod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod    = {32'd0, a} * {32'd0, b};
  assign div_zero = (b == 32'd0);
  assign dvs      = div_zero ? 32'd1 : b;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = sprod;
      MDU_MULTU: {res_hi, res_lo} = uprod;
      MDU_DIV: begin
        res_hi = $signed(a) % $signed(dvs);
        res_lo = $signed(a) / $signed(dvs);
      end
      MDU_DIVU: begin
        res_hi = a % dvs;
        res_lo = a / dvs;
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {res_hi, res_lo} = sprod;
      MDU_MADDU: {res_hi, res_lo} = uprod;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_scheduler.sv
// MDU sequencer: starts mult/div, counts down latency, owns HI/LO; MDU_MADD_EN adds madd/maddu.
// Results land in HI/LO exactly MULT_LAT/DIV_LAT cycles after the start edge.
// Stalls D whenever an MDU instruction there would see an unfinished operation.
module mdu_scheduler
  import mdu_scheduler_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT_DEF,
  parameter int DIV_LAT  = MDU_DIV_LAT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mdu_scheduler_if.slave mdu
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  mdu_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hi_q, lo_q, phi_q, plo_q;
  logic [31:0]   res_hi, res_lo;
  logic [63:0]   wr_val;
  logic          pend_wr_q;
  logic          go, md_op, md_start, complete, busy, div_zero;

  mdu_core u_core (
    .op       (mdu.type_E),
    .a        (mdu.a),
    .b        (mdu.b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign go       = mdu.start_E & ~mdu.kill;
  assign md_op    = is_md(mdu.type_E);
  assign md_start = go & md_op & ~busy;
  assign complete = (state_q == ST_RUN) && (count_q == CW'(1));

`ifdef MDU_MADD_EN
  logic pend_acc_q;
  // Accumulate base is the HI/LO value at completion, not at start.
  assign wr_val = pend_acc_q ? ({hi_q, lo_q} + {phi_q, plo_q}) : {phi_q, plo_q};

  always_ff @(posedge clk) begin
    if (reset)
      pend_acc_q <= 1'b0;
    else if (md_start)
      pend_acc_q <= (mdu.type_E == MDU_MADD) || (mdu.type_E == MDU_MADDU);
  end
`else
  assign wr_val = {phi_q, plo_q};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      phi_q     <= '0;
      plo_q     <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (md_start) begin
        phi_q     <= res_hi;
        plo_q     <= res_lo;
        pend_wr_q <= ~(is_div(mdu.type_E) & div_zero);
      end
      if (complete) begin
        if (pend_wr_q) begin
          hi_q <= wr_val[63:32];
          lo_q <= wr_val[31:0];
        end
      end else if (go && !busy) begin
        if (mdu.type_E == MDU_MTHI) hi_q <= mdu.a;
        if (mdu.type_E == MDU_MTLO) lo_q <= mdu.a;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          state_d = ST_RUN;
          count_d = is_div(mdu.type_E) ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end
      end
      ST_RUN: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_RUN);
    mdu.busy  = busy;
    mdu.stall = mdu.mdu_D & (busy | (go & md_op));
    mdu.hi    = hi_q;
    mdu.lo    = lo_q;
    case (mdu.type_E)
      MDU_MFHI: mdu.rdata = hi_q;
      MDU_MFLO: mdu.rdata = lo_q;
      default:  mdu.rdata = '0;
    endcase
  end

  // The D-stage stall must keep every md start away from a busy unit.
  start_while_busy: assert property (@(posedge clk) disable iff (reset) !(go && md_op && busy));

endmodule

// File: tb/tb_mdu_scheduler.sv
// Scoreboard bench for mdu_scheduler: a transaction-level HI/LO model predicts every cycle's outputs.
module tb_mdu_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_scheduler_if bus ();

  mdu_scheduler #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  typedef struct {
    logic        busy;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural HI/LO plus one pending result with its due edge.
  int unsigned cyc = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          p_on = 0, p_wr = 0, p_acc = 0;
  int unsigned p_done = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit ref_md(input logic [3:0] t);
    bit r;
    r = (t >= 1 && t <= 4);
`ifdef MDU_MADD_EN
    if (t == 9 || t == 10) r = 1;
`endif
    return r;
  endfunction

  task automatic ref_issue(input logic [3:0] t, input logic [31:0] av, input logic [31:0] bv);
    int ia, ib;
    longint la, lb, sp, q, r;
    longint unsigned up;
    ia = av; ib = bv;
    la = ia; lb = ib;
    p_wr  = 1;
    p_acc = (t == 9 || t == 10);
    if (t == 1 || t == 9) begin
      sp = la * lb;
      {p_hi, p_lo} = sp;
    end else if (t == 2 || t == 10) begin
      up = longint'({32'd0, av}) * longint'({32'd0, bv});
      {p_hi, p_lo} = up;
    end else if (bv == 0) begin
      p_wr = 0;
    end else if (t == 3) begin
      q = la / lb; r = la % lb;
      p_hi = r[31:0]; p_lo = q[31:0];
    end else begin
      p_hi = av % bv; p_lo = av / bv;
    end
    p_on   = 1;
    p_done = cyc + ((t == 3 || t == 4) ? 10 : 5);
  endtask

  // One E-stage cycle: predict, push, drive, then advance the model past the edge.
  task automatic step(input bit rst, input logic [3:0] t, input bit st, input bit kl,
                      input logic [31:0] av, input logic [31:0] bv, input bit md);
    exp_t e;
    bit busy_e, go;
    #1;
    busy_e  = p_on;
    go      = st && !kl;
    e.busy  = busy_e;
    e.stall = md && (busy_e || (go && ref_md(t)));
    e.rdata = (t == 5) ? m_hi : (t == 6) ? m_lo : 32'd0;
    e.hi    = m_hi;
    e.lo    = m_lo;
    exp_q.push_back(e);
    reset = rst; bus.type_E = t; bus.start_E = st; bus.kill = kl;
    bus.a = av; bus.b = bv; bus.mdu_D = md;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_hi = 0; m_lo = 0; p_on = 0;
    end else if (p_on && cyc == p_done) begin
      p_on = 0;
      if (p_wr) begin
        if (p_acc) {m_hi, m_lo} = {m_hi, m_lo} + {p_hi, p_lo};
        else begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (go && !busy_e) begin
      if (ref_md(t)) ref_issue(t, av, bv);
      else if (t == 7) m_hi = av;
      else if (t == 8) m_lo = av;
    end
  endtask

  task automatic idle(input int n, input bit md);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, md);
  endtask

  // Monitor: every cycle with a prediction is compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy",  {31'd0, bus.busy},  {31'd0, e.busy});
        chk("stall", {31'd0, bus.stall}, {31'd0, e.stall});
        chk("rdata", bus.rdata, e.rdata);
        chk("hi",    bus.hi,    e.hi);
        chk("lo",    bus.lo,    e.lo);
      end
    end
  end

  initial begin
    logic [3:0]  t;
    logic [31:0] av, bv;
    bit st, kl, md;
    reset = 1; bus.type_E = 0; bus.start_E = 0; bus.kill = 0;
    bus.a = 0; bus.b = 0; bus.mdu_D = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    reset = 0;
    @(posedge clk);

    step(0, 1, 1, 0, -32'sd3, 32'd7, 0);
    idle(5, 0);
    #1; chk("mult_hi", bus.hi, 32'hFFFFFFFF); chk("mult_lo", bus.lo, 32'hFFFFFFEB);

    step(0, 4, 1, 0, 32'd100, 32'd7, 0);
    idle(10, 0);
    #1; chk("divu_hi", bus.hi, 32'd2); chk("divu_lo", bus.lo, 32'd14);
    step(0, 3, 1, 0, -32'sd7, 32'd2, 0);
    idle(10, 0);
    #1; chk("div_hi", bus.hi, 32'hFFFFFFFF); chk("div_lo", bus.lo, 32'hFFFFFFFD);

    // mflo waiting in D behind a mult
    step(0, 1, 1, 0, 32'd6, 32'd9, 1);
    idle(5, 1);
    step(0, 6, 1, 0, 0, 0, 0);
    #1; chk("mflo_rdata", bus.rdata, 32'd54);

    step(0, 7, 1, 0, 32'h1234, 0, 0);
    step(0, 3, 1, 0, 32'd5, 32'd0, 0);
    idle(10, 0);
    #1; chk("div0_hi", bus.hi, 32'h1234); chk("div0_lo", bus.lo, 32'd54);

    step(0, 8, 1, 1, 32'h55, 0, 0);
    #1; chk("kill_mtlo", bus.lo, 32'd54);
    step(0, 1, 1, 1, 32'd3, 32'd3, 0);
    #1; chk("kill_mult_busy", {31'd0, bus.busy}, 32'd0);

    step(0, 3, 1, 0, 32'd50, 32'd3, 0);
    idle(2, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_stall", {31'd0, bus.stall}, 32'd0);
    idle(12, 1);

`ifdef MDU_MADD_EN
    step(0, 8, 1, 0, 32'd10, 0, 0);
    step(0, 9, 1, 0, 32'd3, 32'd4, 0);
    idle(5, 0);
    #1; chk("madd_lo", bus.lo, 32'd22);
`endif

    for (int n = 0; n < 3000; n++) begin
      t  = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 9) != 0);
      kl = ($urandom_range(0, 9) == 0);
      md = $urandom_range(0, 1) == 1;
      av = $urandom();
      case ($urandom_range(0, 3))
        0: bv = 0;
        1: bv = $urandom_range(1, 20);
        2: bv = -$urandom_range(1, 20);
        default: bv = $urandom();
      endcase
      if (p_on && st && !kl && ref_md(t)) st = 0;
      step(($urandom_range(0, 99) == 0), t, st, kl, av, bv, md);
    end
    idle(12, 0);

    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
